alu_arbiter: RTL

- Shares one combinational 64-bit ALU (ops: add, sub, and, or, xor) among NREQ requesters, e.g. issue lanes or the address-generation path.
- Arbitrates round-robin and computes in the grant cycle.
- Registers the result in a one-entry output stage tagged with the owner ID.
- Returns the result to that owner over a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit ALU among NREQ requesters.
// Result is held in a one-entry output stage tagged with its owner.
module alu64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_y
);
    always_comb begin
        o_y = '0;
        case (i_op)
            3'b000:  o_y = i_a + i_b;
            3'b001:  o_y = i_a - i_b;
            3'b010:  o_y = i_a & i_b;
            3'b011:  o_y = i_a | i_b;
            3'b100:  o_y = i_a ^ i_b;
            default: o_y = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 64,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id
);
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rr_ptr;

    logic             w_drain;
    logic             w_can_accept;
    logic             w_found;
    logic [IDW-1:0]   w_sel;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_y;
    logic [IDW-1:0]   w_next_ptr;

    assign w_drain      = r_full && resp_ready[r_id];
    assign w_can_accept = !r_full || w_drain;

    // Search from the pointer upward, wrapping modulo NREQ.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_sel   = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_sel   = IDW'(j);
            end
        end
    end

    assign w_accept = rst_n && w_can_accept && w_found;

    always_comb begin
        req_ready = '0;
        if (w_accept)
            req_ready[w_sel] = 1'b1;
    end

    assign w_a  = req_a[int'(w_sel)*WIDTH +: WIDTH];
    assign w_b  = req_b[int'(w_sel)*WIDTH +: WIDTH];
    assign w_op = req_op[int'(w_sel)*3 +: 3];

    alu64 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_op (w_op),
        .o_y  (w_y)
    );

    assign w_next_ptr = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= 1'b0;
            r_data   <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_full   <= 1'b1;
            r_data   <= w_y;
            r_id     <= w_sel;
            r_rr_ptr <= w_next_ptr;
        end else if (w_drain) begin
            r_full   <= 1'b0;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (r_full)
            resp_valid[r_id] = 1'b1;
    end

    assign resp_data = r_data;
    assign resp_id   = r_id;
endmodule
